ex_mem_reg: RTL and testbench

EX/MEM pipeline register of the 5-stage 16-bit core. It captures the execute-stage result each cycle and presents it to the memory stage. That result comes from the ALU and its sub-units: ADD/SUB, XOR, shifts, PADDSB, and the RED nibble-reduction unit whose sign-extended 16-bit sum lands here. It also owns the architectural Z/V/N flag register that branch resolution reads. Stall and flush controls come from the hazard unit.

---
 rtl/core_pkg.sv | 32 +++
 rtl/flag_reg.sv | 29 ++
 rtl/ex_mem_reg.sv | 117 +++++++++++
 tb/tb_ex_mem_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcode map and flag-update classification.
package core_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Arithmetic and logical/shift ops write Z; RED and PADDSB do not.
    function automatic logic sets_zflag(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    // Only ADD/SUB produce meaningful overflow and sign.
    function automatic logic sets_vnflag(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural Z/V/N flag register; updates only on an enabled, flag-setting op.
module flag_reg
    import core_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    output logic [2:0]    flags   // {z, v, n}
);

    // Z from any flag-setting op; V/N only from ADD/SUB, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (en) begin
            if (sets_zflag(opcode))  flags[2] <= (result == '0);
            if (sets_vnflag(opcode)) begin
                flags[1] <= ovfl;
                flags[0] <= result[DW-1];
            end
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with sticky halt and optional flag register.
// Optional feature: define FLAG_REG_EN to build the Z/V/N flag register;
// otherwise the flags read as 0 and no flag state exists.
module ex_mem_reg
    import core_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          ex_alu_ovfl,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_dst_reg,
    input  logic          ex_reg_wr,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic          ex_halt,
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_alu_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_dst_reg,
    output logic          mem_reg_wr,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic          mem_halt,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);

    typedef struct packed {
        logic          valid;
        logic [3:0]    opcode;
        logic [DW-1:0] alu_result;
        logic [DW-1:0] store_data;
        logic [RW-1:0] dst_reg;
        logic          reg_wr;
        logic          mem_rd;
        logic          mem_wr;
        logic          halt;
    } mem_t;

    mem_t mem_q, mem_d;

    // Next-state: flush > stall > sticky-halt bubble > normal capture.
    always_comb begin
        mem_d = mem_q;
        if (flush) begin
            mem_d = '0;
        end else if (stall) begin
            mem_d = mem_q;
        end else if (mem_q.halt) begin
            mem_d      = '0;
            mem_d.halt = 1'b1;
        end else begin
            mem_d.valid      = ex_valid;
            mem_d.opcode     = ex_opcode;
            mem_d.alu_result = ex_alu_result;
            mem_d.store_data = ex_store_data;
            mem_d.dst_reg    = ex_dst_reg;
            mem_d.reg_wr     = ex_reg_wr & ex_valid;
            mem_d.mem_rd     = ex_mem_rd & ex_valid;
            mem_d.mem_wr     = ex_mem_wr & ex_valid;
            mem_d.halt       = ex_halt   & ex_valid;
        end
    end

    // MEM-side register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign mem_valid      = mem_q.valid;
    assign mem_opcode     = mem_q.opcode;
    assign mem_alu_result = mem_q.alu_result;
    assign mem_store_data = mem_q.store_data;
    assign mem_dst_reg    = mem_q.dst_reg;
    assign mem_reg_wr     = mem_q.reg_wr;
    assign mem_mem_rd     = mem_q.mem_rd;
    assign mem_mem_wr     = mem_q.mem_wr;
    assign mem_halt       = mem_q.halt;

`ifdef FLAG_REG_EN
    // A halted pipe captures only bubbles, so it must not touch the flags.
    logic       flag_en;
    logic [2:0] flags;

    assign flag_en = ex_valid & ~flush & ~stall & ~mem_q.halt;

    flag_reg #(.DW(DW)) u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (flag_en),
        .opcode (ex_opcode),
        .result (ex_alu_result),
        .ovfl   (ex_alu_ovfl),
        .flags  (flags)
    );

    assign {flag_z, flag_v, flag_n} = flags;
`else
    logic unused_ovfl;
    assign unused_ovfl = ex_alu_ovfl;
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed literal checks plus random
// traffic compared every cycle against a spec-level model.
module tb_ex_mem_reg;

`ifdef FLAG_REG_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic        ex_valid = 1'b0, ex_alu_ovfl = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [15:0] ex_alu_result = '0, ex_store_data = '0;
    logic [3:0]  ex_dst_reg = '0;
    logic        ex_reg_wr = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0, ex_halt = 1'b0;
    logic        mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt;
    logic [3:0]  mem_opcode, mem_dst_reg;
    logic [15:0] mem_alu_result, mem_store_data;
    logic        flag_z, flag_v, flag_n;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    ex_mem_reg #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result),
        .ex_alu_ovfl(ex_alu_ovfl), .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
        .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_dst_reg(mem_dst_reg), .mem_reg_wr(mem_reg_wr),
        .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_halt(mem_halt),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what MEM must hold, derived from the operating rules.
    logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halt, m_z, m_v, m_n;
    logic [3:0]  m_op, m_dst;
    logic [15:0] m_res, m_sd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halt, m_z, m_v, m_n} <= '0;
            m_op <= '0; m_dst <= '0; m_res <= '0; m_sd <= '0;
        end else if (flush) begin
            {m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halt} <= '0;
            m_op <= '0; m_dst <= '0; m_res <= '0; m_sd <= '0;
        end else if (!stall) begin
            if (m_halt) begin
                {m_valid, m_reg_wr, m_mem_rd, m_mem_wr} <= '0;
                m_op <= '0; m_dst <= '0; m_res <= '0; m_sd <= '0;
            end else begin
                m_valid  <= ex_valid;
                m_op     <= ex_opcode;
                m_res    <= ex_alu_result;
                m_sd     <= ex_store_data;
                m_dst    <= ex_dst_reg;
                m_reg_wr <= ex_valid && ex_reg_wr;
                m_mem_rd <= ex_valid && ex_mem_rd;
                m_mem_wr <= ex_valid && ex_mem_wr;
                m_halt   <= ex_valid && ex_halt;
                if (FE && ex_valid) begin
                    case (ex_opcode)
                        4'd0, 4'd1: begin
                            m_z <= (ex_alu_result == 16'd0);
                            m_v <= ex_alu_ovfl;
                            m_n <= ex_alu_result[15];
                        end
                        4'd2, 4'd4, 4'd5, 4'd6: m_z <= (ex_alu_result == 16'd0);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("mdl_valid",  mem_valid,      m_valid);
            chk("mdl_opcode", mem_opcode,     m_op);
            chk("mdl_result", mem_alu_result, m_res);
            chk("mdl_sdata",  mem_store_data, m_sd);
            chk("mdl_dst",    mem_dst_reg,    m_dst);
            chk("mdl_ctrl",   {mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt},
                              {m_reg_wr, m_mem_rd, m_mem_wr, m_halt});
            chk("mdl_flags",  {flag_z, flag_v, flag_n}, {m_z, m_v, m_n});
        end
    end

    task automatic idle();
        ex_valid = 0; ex_opcode = 0; ex_alu_result = 0; ex_alu_ovfl = 0;
        ex_store_data = 0; ex_dst_reg = 0; ex_reg_wr = 0; ex_mem_rd = 0;
        ex_mem_wr = 0; ex_halt = 0; stall = 0; flush = 0;
    endtask

    task automatic put(input logic [3:0] op, input logic [15:0] res, input logic ov);
        @(negedge clk);
        idle();
        ex_valid = 1; ex_opcode = op; ex_alu_result = res; ex_alu_ovfl = ov;
        ex_halt = (op == 4'hF);
    endtask

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_valid", mem_valid, 1'b0);
        chk("rst_flags", {flag_z, flag_v, flag_n}, 3'b000);
        chk_en = 1;

        // RED pass-through: flags untouched.
        put(4'h3, 16'hFFF8, 1'b0); ex_reg_wr = 1; ex_dst_reg = 4'd5;
        edge1();
        chk("red_result", mem_alu_result, 16'hFFF8);
        chk("red_dst",    mem_dst_reg, 4'd5);
        chk("red_regwr",  mem_reg_wr, 1'b1);
        chk("red_flags",  {flag_z, flag_v, flag_n}, 3'b000);

        // SUB zero sets Z; XOR non-zero clears Z, V/N held.
        put(4'h1, 16'h0000, 1'b0); edge1();
        chk("sub_flags", {flag_z, flag_v, flag_n}, {FE, 2'b00});
        put(4'h2, 16'h8001, 1'b0); edge1();
        chk("xor_flags", {flag_z, flag_v, flag_n}, 3'b000);

        // Three-cycle stall with ADD 0 waiting in EX.
        put(4'h0, 16'h0000, 1'b0); stall = 1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("stall_op",  mem_opcode, 4'h2);
            chk("stall_res", mem_alu_result, 16'h8001);
            chk("stall_z",   flag_z, 1'b0);
        end
        @(negedge clk); stall = 0;
        edge1();
        chk("unstall_op", mem_opcode, 4'h0);
        chk("unstall_z",  flag_z, FE);

        // Flush beats stall with an SW in EX.
        put(4'h9, 16'h1234, 1'b0); ex_mem_wr = 1; flush = 1; stall = 1;
        edge1();
        chk("flush_valid", mem_valid, 1'b0);
        chk("flush_memwr", mem_mem_wr, 1'b0);
        chk("flush_z",     flag_z, FE);

        // Build flags 111 with a valid MEM entry, then async reset mid-cycle.
        put(4'h0, 16'h8000, 1'b1); edge1();
        chk("add_vn", {flag_z, flag_v, flag_n}, {1'b0, FE, FE});
        put(4'h2, 16'h0000, 1'b0); edge1();
        chk("pre_rst_flags", {flag_z, flag_v, flag_n}, {FE, FE, FE});
        chk("pre_rst_valid", mem_valid, 1'b1);
        #1 rst = 1;
        #1;
        chk("async_valid", mem_valid, 1'b0);
        chk("async_flags", {flag_z, flag_v, flag_n}, 3'b000);
        chk("async_op",    mem_opcode, 4'h0);
        rst = 0;

        // Sticky halt: following ADD becomes a bubble, Z untouched.
        put(4'hF, 16'h0000, 1'b0); edge1();
        chk("hlt_halt",  mem_halt, 1'b1);
        chk("hlt_valid", mem_valid, 1'b1);
        put(4'h0, 16'h0000, 1'b0); edge1();
        chk("hlt_add_valid", mem_valid, 1'b0);
        chk("hlt_add_halt",  mem_halt, 1'b1);
        chk("hlt_add_z",     flag_z, 1'b0);
        @(negedge clk); idle(); flush = 1;
        edge1();
        chk("hlt_flush", mem_halt, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ex_valid      = ($urandom_range(0, 9) != 0);
            ex_opcode     = 4'($urandom_range(0, 15));
            ex_alu_result = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            ex_alu_ovfl   = 1'($urandom);
            ex_store_data = 16'($urandom);
            ex_dst_reg    = 4'($urandom);
            ex_reg_wr     = 1'($urandom);
            ex_mem_rd     = 1'($urandom);
            ex_mem_wr     = 1'($urandom);
            ex_halt       = (ex_opcode == 4'hF) && ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk); #2 rst = 1; #1 rst = 0;
            end
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
